// File: rtl/gateway_rx_pkg.sv
// Shared types and helpers for the gateway event-link receiver.
package gateway_rx_pkg;

    localparam int FLAG_W       = 3;
    localparam int FRAME_DATA_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    function automatic logic majority(input logic [FLAG_W-1:0] f);
        return (f[0] & f[1]) | (f[0] & f[2]) | (f[1] & f[2]);
    endfunction

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/gateway_event_receiver_rx_bit_sampler.sv
// Rx synchronizer and bit-period timer; strobes mid-bit once enabled.
module rx_bit_sampler #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    input  logic en_i,
    output logic strobe_o,
    output logic bit_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            // Disabled timer preloads half a bit so the first strobe lands mid start bit.
            if (!en_i)
                cnt_q <= HALF_M1;
            else if (cnt_q == '0)
                cnt_q <= FULL_M1;
            else
                cnt_q <= cnt_q - 1'b1;
        end
    end

    assign strobe_o = en_i && (cnt_q == '0);
    assign bit_o    = sync_q[1];

endmodule

// File: rtl/gateway_event_receiver.sv
// Event-link frame receiver with alarm confirmation.
// Define GATEWAY_RX_PARITY_EN to receive and check the even-parity bit.
module gateway_event_receiver
    import gateway_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 16,
    parameter int EVENT_CONFIRM = 2,
    parameter int CLEAR_FRAMES  = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Rx,
    output logic [FLAG_W-1:0] Flag_Out,
    output logic              Event_Out,
    output logic              Frame_Valid,
    output logic              Frame_Error,
    output logic              Alarm,
    output logic [7:0]        Event_Count
);
    rx_state_e               state_q;
    logic [1:0]              bit_cnt_q;
    logic [FRAME_DATA_W-1:0] data_q;
    logic                    wait_high_q;
    logic [FLAG_W-1:0]       flag_q;
    logic                    event_q, valid_q, error_q, alarm_q;
    logic [3:0]              evt_run_q, clr_run_q;
    logic [7:0]              evt_cnt_q;

    logic strobe, rx_bit;
    logic consistent_ok, parity_ok, frame_ok;
    logic [3:0] evt_inc, clr_inc;

    rx_bit_sampler #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_sampler (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .rx_i     (Rx),
        .en_i     (state_q != IDLE),
        .strobe_o (strobe),
        .bit_o    (rx_bit)
    );

`ifdef GATEWAY_RX_PARITY_EN
    logic par_q;
    assign parity_ok = ~^{par_q, data_q};
`else
    assign parity_ok = 1'b1;
`endif

    // data_q = {E, F2, F1, F0} once all data bits are in
    assign consistent_ok = (data_q[3] == majority(data_q[FLAG_W-1:0]));
    assign frame_ok      = parity_ok && consistent_ok;
    assign evt_inc       = sat_inc4(evt_run_q);
    assign clr_inc       = sat_inc4(clr_run_q);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            data_q      <= '0;
            wait_high_q <= 1'b0;
            flag_q      <= '0;
            event_q     <= 1'b0;
            valid_q     <= 1'b0;
            error_q     <= 1'b0;
            alarm_q     <= 1'b0;
            evt_run_q   <= '0;
            clr_run_q   <= '0;
            evt_cnt_q   <= '0;
`ifdef GATEWAY_RX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            valid_q <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // After a framing error the line must go high before a new start is trusted.
                    if (wait_high_q) begin
                        if (rx_bit) wait_high_q <= 1'b0;
                    end else if (!rx_bit) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (strobe) begin
                        if (!rx_bit) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (strobe) begin
                        data_q    <= {rx_bit, data_q[FRAME_DATA_W-1:1]};
                        bit_cnt_q <= bit_cnt_q + 2'd1;
                        if (bit_cnt_q == 2'd3) begin
`ifdef GATEWAY_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
                end
`ifdef GATEWAY_RX_PARITY_EN
                PARITY: begin
                    if (strobe) begin
                        par_q   <= rx_bit;
                        state_q <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (strobe) begin
                        state_q <= IDLE;
                        if (!rx_bit) begin
                            error_q     <= 1'b1;
                            wait_high_q <= 1'b1;
                        end else if (!frame_ok) begin
                            error_q <= 1'b1;
                        end else begin
                            valid_q <= 1'b1;
                            flag_q  <= data_q[FLAG_W-1:0];
                            event_q <= data_q[3];
                            if (data_q[3]) begin
                                evt_run_q <= evt_inc;
                                clr_run_q <= '0;
                                if (evt_inc >= 4'(EVENT_CONFIRM)) alarm_q <= 1'b1;
                                if (evt_cnt_q != 8'hFF) evt_cnt_q <= evt_cnt_q + 8'd1;
                            end else begin
                                clr_run_q <= clr_inc;
                                evt_run_q <= '0;
                                if (alarm_q && clr_inc >= 4'(CLEAR_FRAMES)) alarm_q <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Flag_Out    = flag_q;
    assign Event_Out   = event_q;
    assign Frame_Valid = valid_q;
    assign Frame_Error = error_q;
    assign Alarm       = alarm_q;
    assign Event_Count = evt_cnt_q;

endmodule

// File: tb/tb_gateway_event_receiver.sv
// Directed bench for gateway_event_receiver (works with or without GATEWAY_RX_PARITY_EN).
module tb_gateway_event_receiver;
    import gateway_rx_pkg::*;

    localparam int CPB = 16;
`ifdef GATEWAY_RX_PARITY_EN
    localparam int LAT = 107;
`else
    localparam int LAT = 91;
`endif

    logic       Clk = 1'b0;
    logic       Reset, Rx;
    logic [2:0] Flag_Out;
    logic       Event_Out, Frame_Valid, Frame_Error, Alarm;
    logic [7:0] Event_Count;

    int cyc = 0, nv = 0, ne = 0, nboth = 0, v_cyc = 0, start_cyc = 0;
    logic v_alarm = 1'b0;
    int n_checks = 0, n_pass = 0, n_fail = 0;
    int nv0, ne0;

    gateway_event_receiver #(
        .CLKS_PER_BIT(CPB), .EVENT_CONFIRM(2), .CLEAR_FRAMES(3)
    ) dut (
        .Clk(Clk), .Reset(Reset), .Rx(Rx),
        .Flag_Out(Flag_Out), .Event_Out(Event_Out),
        .Frame_Valid(Frame_Valid), .Frame_Error(Frame_Error),
        .Alarm(Alarm), .Event_Count(Event_Count)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    always @(negedge Clk) begin
        if (Frame_Valid) begin
            nv++;
            v_cyc   = cyc;
            v_alarm = Alarm;
        end
        if (Frame_Error) ne++;
        if (Frame_Valid && Frame_Error) nboth++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        Rx = b;
        repeat (CPB) @(negedge Clk);
    endtask

    task automatic send_frame(input logic [2:0] f, input logic e, input logic pflip, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(f[i]);
        send_bit(e);
`ifdef GATEWAY_RX_PARITY_EN
        send_bit((^{f, e}) ^ pflip);
`else
        if (pflip) Rx = 1'b1;
`endif
        send_bit(stop);
    endtask

    task automatic chk_outs(input string tag, input logic [2:0] f, input logic e,
                            input logic a, input logic [7:0] ec);
        chk({tag, ".flag"},  Flag_Out, f);
        chk({tag, ".event"}, Event_Out, e);
        chk({tag, ".alarm"}, Alarm, a);
        chk({tag, ".count"}, Event_Count, ec);
    endtask

    initial begin
        Reset = 1'b1;
        Rx    = 1'b1;
        repeat (3) @(negedge Clk);
        chk_outs("reset", 3'd0, 1'b0, 1'b0, 8'd0);
        chk("reset.valid", Frame_Valid, 1'b0);
        chk("reset.error", Frame_Error, 1'b0);
        Reset = 1'b0;
        repeat (5) @(negedge Clk);

        // two back-to-back event frames confirm the alarm
        send_frame(3'b111, 1'b1, 1'b0, 1'b1);
        chk("f1.nv", nv, 1);
        chk("f1.latency", v_cyc - start_cyc, LAT);
        chk_outs("f1", 3'd7, 1'b1, 1'b0, 8'd1);
        send_frame(3'b111, 1'b1, 1'b0, 1'b1);
        chk("f2.nv", nv, 2);
        chk("f2.latency", v_cyc - start_cyc, LAT);
        chk("f2.alarm_at_valid", v_alarm, 1'b1);
        chk_outs("f2", 3'd7, 1'b1, 1'b1, 8'd2);

        // non-event frames; alarm clears on the third
        send_frame(3'b001, 1'b0, 1'b0, 1'b1);
        chk_outs("c1", 3'd1, 1'b0, 1'b1, 8'd2);
        send_frame(3'b000, 1'b0, 1'b0, 1'b1);
        chk_outs("c2", 3'd0, 1'b0, 1'b1, 8'd2);
        send_frame(3'b010, 1'b0, 1'b0, 1'b1);
        chk_outs("c3", 3'd2, 1'b0, 1'b0, 8'd2);
        chk("c3.nv", nv, 5);

        // inconsistent event frame must not touch outputs or run counters
        ne0 = ne; nv0 = nv;
        send_frame(3'b001, 1'b1, 1'b0, 1'b1);
        chk("incons.ne", ne - ne0, 1);
        chk("incons.nv", nv - nv0, 0);
        chk_outs("incons", 3'd2, 1'b0, 1'b0, 8'd2);
        send_frame(3'b110, 1'b1, 1'b0, 1'b1);
        chk_outs("e1", 3'd6, 1'b1, 1'b0, 8'd3);
        send_frame(3'b011, 1'b1, 1'b0, 1'b1);
        chk_outs("e2", 3'd3, 1'b1, 1'b1, 8'd4);

        // parity error (or a second consistency error without parity)
        ne0 = ne; nv0 = nv;
`ifdef GATEWAY_RX_PARITY_EN
        send_frame(3'b111, 1'b1, 1'b1, 1'b1);
`else
        send_frame(3'b110, 1'b0, 1'b0, 1'b1);
`endif
        chk("perr.ne", ne - ne0, 1);
        chk("perr.nv", nv - nv0, 0);
        chk_outs("perr", 3'd3, 1'b1, 1'b1, 8'd4);

        // stop bit low
        ne0 = ne; nv0 = nv;
        send_frame(3'b000, 1'b0, 1'b0, 1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        chk("stop.ne", ne - ne0, 1);
        chk("stop.nv", nv - nv0, 0);
        chk_outs("stop", 3'd3, 1'b1, 1'b1, 8'd4);

        // short low glitch
        ne0 = ne; nv0 = nv;
        Rx = 1'b0;
        repeat (3) @(negedge Clk);
        Rx = 1'b1;
        repeat (3 * CPB) @(negedge Clk);
        chk("glitch.ne", ne - ne0, 0);
        chk("glitch.nv", nv - nv0, 0);
        chk("glitch.state", dut.state_q, IDLE);

        // reset during DATA
        send_bit(1'b0);
        send_bit(1'b1);
        chk("mid.state", dut.state_q, DATA);
        Reset = 1'b1;
        #1;
        chk_outs("mid_reset", 3'd0, 1'b0, 1'b0, 8'd0);
        chk("mid_reset.state", dut.state_q, IDLE);
        @(negedge Clk);
        Rx = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        nv0 = nv;
        repeat (CPB) @(negedge Clk);
        send_frame(3'b101, 1'b1, 1'b0, 1'b1);
        chk("post.nv", nv - nv0, 1);
        chk_outs("post", 3'd5, 1'b1, 1'b0, 8'd1);
        chk("never_both", nboth, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
